// File: rtl/button_conditioner_if.sv
// Push-button conditioner signal bundle.
// master drives the raw line; slave returns the clean level and strobes.
interface button_conditioner_if;
  logic button_raw;
  logic button_press;
  logic press_pulse;
  logic release_pulse;
  logic long_press;

  modport master (
    output button_raw,
    input  button_press,
    input  press_pulse,
    input  release_pulse,
    input  long_press
  );

  modport slave (
    input  button_raw,
    output button_press,
    output press_pulse,
    output release_pulse,
    output long_press
  );
endinterface

// File: rtl/button_conditioner.sv
// Push-button synchroniser + debouncer with press/release strobes.
// Define BUTTON_LONG_PRESS_EN to add the one-shot long-press strobe.
module button_conditioner #(
  parameter int DEBOUNCE_CYCLES   = 4,
  parameter int LONG_PRESS_CYCLES = 10,
  parameter int CNT_WIDTH         = 8
) (
  input  logic clk,
  input  logic reset,
  button_conditioner_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE,
    DEB_PRESS,
    PRESSED,
    DEB_RELEASE
  } state_t;

  localparam logic [CNT_WIDTH-1:0] DEB_LAST =
    CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

  logic                 sync1;
  logic                 sync2;
  state_t               state;
  logic [CNT_WIDTH-1:0] deb_cnt;
  logic                 pressed;
  logic                 press_q;
  logic                 release_q;

  // Two-flop synchroniser for the asynchronous raw line
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
    end else begin
      sync1 <= bus.button_raw;
      sync2 <= sync1;
    end
  end

  // Debounce FSM with registered level and strobes
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      deb_cnt   <= '0;
      pressed   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      press_q   <= 1'b0;
      release_q <= 1'b0;
      unique case (state)
        IDLE: begin
          pressed <= 1'b0;
          deb_cnt <= '0;
          if (sync2) state <= DEB_PRESS;
        end
        DEB_PRESS: begin
          if (!sync2) begin
            state   <= IDLE;
            deb_cnt <= '0;
          end else if (deb_cnt == DEB_LAST) begin
            state   <= PRESSED;
            deb_cnt <= '0;
            pressed <= 1'b1;
            press_q <= 1'b1;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        PRESSED: begin
          if (!sync2) begin
            state   <= DEB_RELEASE;
            deb_cnt <= '0;
          end
        end
        DEB_RELEASE: begin
          if (sync2) begin
            state <= PRESSED;
          end else if (deb_cnt == DEB_LAST) begin
            state     <= IDLE;
            deb_cnt   <= '0;
            pressed   <= 1'b0;
            release_q <= 1'b1;
          end else begin
            deb_cnt <= deb_cnt + 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.button_press  = pressed;
  assign bus.press_pulse   = press_q;
  assign bus.release_pulse = release_q;

`ifdef BUTTON_LONG_PRESS_EN
  localparam logic [CNT_WIDTH-1:0] LP_LAST =
    CNT_WIDTH'(LONG_PRESS_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] LP_SAT =
    CNT_WIDTH'(LONG_PRESS_CYCLES);

  logic [CNT_WIDTH-1:0] hold_cnt;
  logic                 long_q;

  // Hold timer: runs in PRESSED, pauses across release bounces,
  // saturates one past the fire point so the strobe is one-shot
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hold_cnt <= '0;
      long_q   <= 1'b0;
    end else begin
      long_q <= 1'b0;
      unique case (state)
        IDLE: hold_cnt <= '0;
        DEB_PRESS: begin
          if (sync2 && deb_cnt == DEB_LAST) hold_cnt <= '0;
        end
        PRESSED: begin
          if (hold_cnt == LP_LAST) long_q <= 1'b1;
          if (hold_cnt < LP_SAT) hold_cnt <= hold_cnt + 1'b1;
        end
        DEB_RELEASE: hold_cnt <= hold_cnt;
        default: hold_cnt <= '0;
      endcase
    end
  end

  assign bus.long_press = long_q;
`else
  assign bus.long_press = 1'b0;
`endif

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench for button_conditioner.
// Long-press expectations follow BUTTON_LONG_PRESS_EN.
module tb_button_conditioner;

  localparam int DEB = 4;
  localparam int LP  = 10;
  localparam int LAT = DEB + 3;

  localparam int K_PRESS   = 0;
  localparam int K_RELEASE = 1;
  localparam int K_LONG    = 2;

  typedef struct {
    int kind;
    int at;
  } ev_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   vectors = 0;
  int   miscompares = 0;
  logic exp_level = 1'b0;
  ev_t  sb[$];

  button_conditioner_if bc_if();

  button_conditioner #(
    .DEBOUNCE_CYCLES  (DEB),
    .LONG_PRESS_CYCLES(LP),
    .CNT_WIDTH        (8)
  ) dut (
    .clk  (clk),
    .reset(rst),
    .bus  (bc_if.slave)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic string kname(int k);
    case (k)
      K_PRESS:   return "press_pulse";
      K_RELEASE: return "release_pulse";
      default:   return "long_press";
    endcase
  endfunction

  task automatic push(int k, int at);
    ev_t e;
    e.kind = k;
    e.at   = at;
    sb.push_back(e);
  endtask

  task automatic take(int k);
    ev_t e;
    vectors++;
    if (sb.size() == 0) begin
      miscompares++;
      $display("FAIL unexpected: %s at cycle %0d, required none",
               kname(k), cyc);
    end else begin
      e = sb.pop_front();
      if (e.kind != k || e.at != cyc) begin
        miscompares++;
        $display("FAIL event: got %s@%0d, required %s@%0d",
                 kname(k), cyc, kname(e.kind), e.at);
      end
      if (e.kind == K_PRESS) exp_level = 1'b1;
      if (e.kind == K_RELEASE) exp_level = 1'b0;
    end
  endtask

  // Monitor: pops an expectation for every strobe the DUT shows
  always @(negedge clk) begin
    if (rst) exp_level = 1'b0;
    if (bc_if.press_pulse === 1'b1) take(K_PRESS);
    if (bc_if.release_pulse === 1'b1) take(K_RELEASE);
    if (bc_if.long_press === 1'b1) take(K_LONG);
    vectors++;
    if (bc_if.button_press !== exp_level) begin
      miscompares++;
      $display("FAIL level: button_press=%b at cycle %0d, required %b",
               bc_if.button_press, cyc, exp_level);
    end
  end

  task automatic chk(string name, logic act);
    vectors++;
    if (act !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: got %b, required 0", name, act);
    end
  endtask

  task automatic check_zero(string tag);
    chk({tag, " button_press"}, bc_if.button_press);
    chk({tag, " press_pulse"}, bc_if.press_pulse);
    chk({tag, " release_pulse"}, bc_if.release_pulse);
    chk({tag, " long_press"}, bc_if.long_press);
  endtask

  task automatic cycles(int n);
    repeat (n) @(negedge clk);
  endtask

  // Clean press held for `hold` cycles, then release
  task automatic press_hold(int hold, bit expect_long);
    int t;
    t = cyc;
    bc_if.button_raw = 1'b1;
    push(K_PRESS, t + LAT);
`ifdef BUTTON_LONG_PRESS_EN
    if (expect_long) push(K_LONG, t + LAT + LP);
`endif
    cycles(hold);
    t = cyc;
    bc_if.button_raw = 1'b0;
    push(K_RELEASE, t + LAT);
    cycles(12);
  endtask

  initial begin
    int t;
    bc_if.button_raw = 1'b0;
    rst = 1'b1;
    cycles(2);
    check_zero("reset");
    rst = 1'b0;
    cycles(3);

    // clean press / release
    press_hold(20, 1'b1);

    // 3-cycle glitch must be rejected
    bc_if.button_raw = 1'b1;
    cycles(3);
    bc_if.button_raw = 1'b0;
    cycles(12);

    // release bounce: 2 low cycles while pressed; hold timer pauses
    t = cyc;
    bc_if.button_raw = 1'b1;
    push(K_PRESS, t + LAT);
    cycles(12);
    bc_if.button_raw = 1'b0;
    cycles(2);
    bc_if.button_raw = 1'b1;
`ifdef BUTTON_LONG_PRESS_EN
    push(K_LONG, t + LAT + LP + 2);
`endif
    cycles(15);
    t = cyc;
    bc_if.button_raw = 1'b0;
    push(K_RELEASE, t + LAT);
    cycles(12);

    // 30-cycle hold: long_press once (or never when compiled out)
    press_hold(30, 1'b1);

    // async reset while pressed, button kept held
    t = cyc;
    bc_if.button_raw = 1'b1;
    push(K_PRESS, t + LAT);
    cycles(12);
    #1 rst = 1'b1;
    #1 check_zero("async reset");
    cycles(2);
    rst = 1'b0;
    t = cyc;
    push(K_PRESS, t + LAT);
    cycles(12);
    t = cyc;
    bc_if.button_raw = 1'b0;
    push(K_RELEASE, t + LAT);
    cycles(12);

    vectors++;
    if (sb.size() != 0) begin
      miscompares++;
      while (sb.size() != 0) begin
        ev_t e;
        e = sb.pop_front();
        $display("FAIL missing: %s@%0d never seen, required once",
                 kname(e.kind), e.at);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
